// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per cycle.
// Fixed latency of WIDTH run cycles plus a single DONE cycle.
module booth_mult_seq #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   operand_a_i,
  input  logic [WIDTH-1:0]   operand_b_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  // ACC is one bit wider than the operands so -2^(WIDTH-1) cannot overflow
  always_comb begin
    sum = acc;
    unique case (1'b1)
      (q[0] & ~q_m1): sum = acc - m;
      (~q[0] & q_m1): sum = acc + m;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      m         <= '0;
      acc       <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
      product_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            m     <= {operand_a_i[WIDTH-1], operand_a_i};
            q     <= operand_b_i;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= CNT_INIT;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= {sum[WIDTH], sum[WIDTH:1]};
          q    <= {sum[0], q[WIDTH-1:1]};
          q_m1 <= q[0];
          cnt  <= cnt - CNT_LAST;
          // low 2*WIDTH bits of the shifted {ACC,Q}
          if (cnt == CNT_LAST) begin
            product_o <= {sum, q[WIDTH-1:1]};
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o = (state == IDLE);
  assign busy_o  = (state == RUN) || (state == DONE);
  assign done_o  = (state == DONE);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: latency-level model plus directed
// literal checks and randomized operand/start traffic.
module tb_booth_mult_seq;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;

  // model: cycles left until idle, pending and visible product
  int             left = 0;
  logic [2*W-1:0] pend = '0;
  logic [2*W-1:0] m_prod = '0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .operand_a_i (a),
    .operand_b_i (b),
    .ready_o     (ready),
    .busy_o      (busy),
    .done_o      (done),
    .product_o   (prod)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      left   = 0;
      m_prod = '0;
    end else if (left == 0) begin
      if (start) begin
        pend = mul(a, b);
        left = W + 1;
      end
    end else begin
      left--;
      if (left == 1) m_prod = pend;
    end
  end

  always @(negedge clk) begin
    chk("ready", 64'(ready), 64'(left == 0));
    chk("busy", 64'(busy), 64'(left != 0));
    chk("done", 64'(done), 64'(left == 1));
    chk("product", 64'(prod), 64'(m_prod));
    if (done) done_cnt++;
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  // one operation; glitch re-pulses start and changes A mid-run
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [2*W-1:0] exp, input bit glitch);
    int n;
    int d0;
    a = x;
    b = y;
    start = 1'b1;
    cyc();
    start = 1'b0;
    d0 = done_cnt;
    chk("ready_after_accept", 64'(ready), 64'd0);
    n = 1;
    while (!done && n < 40) begin
      cyc();
      n++;
      if (glitch && n == 5) begin
        start = 1'b1;
        a = 12'd100;
      end
      if (glitch && n == 6) start = 1'b0;
    end
    chk("latency", 64'(n), 64'(W + 1));
    chk("op_product", 64'(prod), 64'(exp));
    cyc();
    cyc();
    chk("one_done_pulse", 64'(done_cnt - d0), 64'd1);
    chk("idle_after_op", 64'(ready), 64'd1);
  endtask

  initial begin
    int n;
    int last;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", 64'(prod), 64'd0);
    cyc();
    rst = 1'b1;
    cyc();

    chk("model_pin_min", 64'(mul(12'h800, 12'h800)), 64'h400000);
    chk("model_pin_neg", 64'(mul(12'hFF9, 12'd6)), 64'hFFFFD6);

    op(12'd3, 12'd5, 24'h00000F, 1'b0);
    op(12'hFF9, 12'd6, 24'hFFFFD6, 1'b0);
    op(12'd6, 12'hFF9, 24'hFFFFD6, 1'b0);
    op(12'h800, 12'h800, 24'h400000, 1'b0);
    op(12'd2047, 12'h800, 24'hC00800, 1'b0);
    op(12'd3, 12'd5, 24'h00000F, 1'b1);
    op(12'd2, 12'd2, 24'h000004, 1'b0);

    // abort 9x9 at run step 5
    a = 12'd9;
    b = 12'd9;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    rst = 1'b0;
    #1;
    chk("abort_product", 64'(prod), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    cyc();
    rst = 1'b1;
    last = done_cnt;
    repeat (20) cyc();
    chk("no_done_after_abort", 64'(done_cnt - last), 64'd0);

    // start held high: one product every W+2 cycles
    a = 12'd1;
    b = 12'd1;
    start = 1'b1;
    last = -1;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (done) begin
        chk("stream_product", 64'(prod), 64'd1);
        if (last >= 0) chk("stream_period", 64'(k - last), 64'(W + 2));
        last = k;
        n++;
      end
    end
    chk("stream_pulses", 64'(n >= 3), 64'd1);
    start = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      cyc();
      n++;
    end
    chk("stream_drain", 64'(ready), 64'd1);

    // randomized traffic; the model checks every cycle
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = W'($urandom);
      y = W'($urandom);
      if ($urandom_range(0, 3) == 0) x = 12'h800;
      if ($urandom_range(0, 3) == 0) y = ($urandom_range(0, 1) != 0) ? 12'h800 : 12'h7FF;
      a = x;
      b = y;
      start = 1'b1;
      cyc();
      n = 1;
      while (!done && n < 40) begin
        start = ($urandom_range(0, 3) == 0);
        a = W'($urandom);
        b = W'($urandom);
        cyc();
        n++;
      end
      start = 1'b0;
      chk("rand_done_seen", 64'(done), 64'd1);
      chk("rand_product", 64'(prod), 64'(mul(x, y)));
      repeat ($urandom_range(1, 3)) cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
